// File: rtl/spi_slave_regs.sv
// SPI responder with an 8x8 register file, driven by 12-bit commands
// (write flag, address, data). SPI pins are oversampled on clk.
module spi_slave_regs #(
    parameter int CMD_WIDTH  = 12,
    parameter int ADDR_WIDTH = 3,
    parameter int READ_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  sclk,
    input  logic                  cs,
    input  logic                  mosi,
    output logic                  miso,
    output logic                  wr_vld,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [READ_WIDTH-1:0] wr_data,
    output logic                  rd_done,
    input  logic [ADDR_WIDTH-1:0] cfg_addr,
    output logic [READ_WIDTH-1:0] cfg_data
);

    localparam int NREGS = 2 ** ADDR_WIDTH;
    localparam int CNT_W = $clog2(CMD_WIDTH + 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CMD  = 2'd1;
    localparam logic [1:0] ST_RD   = 2'd2;
    localparam logic [1:0] ST_WAIT = 2'd3;

    logic [1:0]            r_sclk_sync;
    logic                  r_sclk_d;
    logic [1:0]            r_cs_sync;
    logic [1:0]            r_mosi_sync;
    logic [1:0]            r_sync_vld;
    logic [1:0]            r_state;
    logic                  r_armed;
    logic [CNT_W-1:0]      r_cnt;
    logic [CMD_WIDTH-2:0]  r_shreg;
    logic [READ_WIDTH-1:0] r_tx;
    logic [READ_WIDTH-1:0] r_regs [NREGS];
    logic                  r_miso;
    logic                  r_wr_vld;
    logic [ADDR_WIDTH-1:0] r_wr_addr;
    logic [READ_WIDTH-1:0] r_wr_data;
    logic                  r_rd_done;

    logic                  w_sclk_s;
    logic                  w_cs_s;
    logic                  w_mosi_s;
    logic                  w_rise;
    logic                  w_fall;
    logic [CMD_WIDTH-1:0]  w_cmd;
    logic                  w_wr_flag;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [READ_WIDTH-1:0] w_data;

    assign w_sclk_s  = r_sclk_sync[1];
    assign w_cs_s    = r_cs_sync[1];
    assign w_mosi_s  = r_mosi_sync[1];
    assign w_rise    = w_sclk_s & ~r_sclk_d;
    assign w_fall    = ~w_sclk_s & r_sclk_d;
    assign w_cmd     = {r_shreg, w_mosi_s};
    assign w_wr_flag = w_cmd[CMD_WIDTH-1];
    assign w_addr    = w_cmd[CMD_WIDTH-2 -: ADDR_WIDTH];
    assign w_data    = w_cmd[READ_WIDTH-1:0];

    assign miso     = r_miso;
    assign wr_vld   = r_wr_vld;
    assign wr_addr  = r_wr_addr;
    assign wr_data  = r_wr_data;
    assign rd_done  = r_rd_done;
    assign cfg_data = r_regs[cfg_addr];

    // Pin synchronisers; r_sync_vld marks when cs_s carries a real pin sample
    // rather than its reset value, so a frame live at reset release is not armed.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sclk_sync <= 2'b00;
            r_sclk_d    <= 1'b0;
            r_cs_sync   <= 2'b11;
            r_mosi_sync <= 2'b00;
            r_sync_vld  <= 2'b00;
        end else begin
            r_sclk_sync <= {r_sclk_sync[0], sclk};
            r_sclk_d    <= r_sclk_sync[1];
            r_cs_sync   <= {r_cs_sync[0], cs};
            r_mosi_sync <= {r_mosi_sync[0], mosi};
            r_sync_vld  <= {r_sync_vld[0], 1'b1};
        end
    end

    // Frame FSM, register file, serial shifters and output pulses.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_armed   <= 1'b0;
            r_cnt     <= '0;
            r_shreg   <= '0;
            r_tx      <= '0;
            r_miso    <= 1'b0;
            r_wr_vld  <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
            r_rd_done <= 1'b0;
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            r_wr_vld  <= 1'b0;
            r_rd_done <= 1'b0;
            if (w_cs_s && r_sync_vld[1]) begin
                r_armed <= 1'b1;
            end
            if (w_cs_s) begin
                r_state <= ST_IDLE;
                r_cnt   <= '0;
                r_miso  <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        r_cnt  <= '0;
                        r_miso <= 1'b0;
                        if (r_armed) begin
                            r_state <= ST_CMD;
                        end
                    end
                    ST_CMD: begin
                        if (w_rise) begin
                            r_shreg <= w_cmd[CMD_WIDTH-2:0];
                            r_cnt   <= r_cnt + CNT_W'(1);
                            if (r_cnt == CNT_W'(CMD_WIDTH - 1)) begin
                                r_cnt <= '0;
                                if (w_wr_flag) begin
                                    r_regs[w_addr] <= w_data;
                                    r_wr_vld       <= 1'b1;
                                    r_wr_addr      <= w_addr;
                                    r_wr_data      <= w_data;
                                    r_state        <= ST_WAIT;
                                end else begin
                                    r_tx    <= r_regs[w_addr];
                                    r_state <= ST_RD;
                                end
                            end
                        end
                    end
                    ST_RD: begin
                        if (w_fall) begin
                            r_miso <= r_tx[READ_WIDTH-1];
                            r_tx   <= {r_tx[READ_WIDTH-2:0], 1'b0};
                        end
                        if (w_rise) begin
                            r_cnt <= r_cnt + CNT_W'(1);
                            if (r_cnt == CNT_W'(READ_WIDTH - 1)) begin
                                r_rd_done <= 1'b1;
                                r_state   <= ST_WAIT;
                            end
                        end
                    end
                    ST_WAIT: begin
                        r_miso <= 1'b0;
                    end
                    default: begin
                        r_state <= ST_IDLE;
                        r_miso  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spi_slave_regs.sv
// Bench for spi_slave_regs: directed vector table, corner-case sequences
// and random frames checked against an array model of the register file.
module tb_spi_slave_regs;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       sclk = 1'b0;
    logic       cs = 1'b1;
    logic       mosi = 1'b0;
    logic       miso;
    logic       wr_vld;
    logic [2:0] wr_addr;
    logic [7:0] wr_data;
    logic       rd_done;
    logic [2:0] cfg_addr = 3'd0;
    logic [7:0] cfg_data;

    spi_slave_regs #(.CMD_WIDTH(12), .ADDR_WIDTH(3), .READ_WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .sclk(sclk), .cs(cs), .mosi(mosi),
        .miso(miso), .wr_vld(wr_vld), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_done(rd_done), .cfg_addr(cfg_addr), .cfg_data(cfg_data)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int wr_cnt = 0;
    int rd_cnt = 0;
    logic [2:0] mon_addr = 3'd0;
    logic [7:0] mon_data = 8'd0;
    logic [7:0] mdl [8];

    typedef struct {
        logic [11:0] cmd;
        int          nrise;
        int          gap;
        logic        exp_wr;
        logic [2:0]  exp_addr;
        logic [7:0]  exp_wdata;
        logic        exp_rd;
        logic [7:0]  exp_rdata;
    } vec_t;

    // Pulse monitor
    always @(negedge clk) begin
        if (rst_n) begin
            if (wr_vld) begin
                wr_cnt   <= wr_cnt + 1;
                mon_addr <= wr_addr;
                mon_data <= wr_data;
            end
            if (rd_done) begin
                rd_cnt <= rd_cnt + 1;
            end
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: run did not finish, got timeout required completion");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    task automatic pulse(input logic b, output logic m);
        mosi = b;
        repeat (10) @(negedge clk);
        sclk = 1'b1;
        m = miso;
        repeat (10) @(negedge clk);
        sclk = 1'b0;
    endtask

    task automatic frame(input logic [11:0] cmd, input int nrise, input int gap,
                         output logic [7:0] rd, output int miso_bad);
        logic m;
        rd = 8'h00;
        miso_bad = 0;
        @(negedge clk);
        cs = 1'b0;
        repeat (5) @(negedge clk);
        for (int i = 0; i < nrise; i++) begin
            pulse((i < 12) ? cmd[11 - i] : 1'($urandom_range(0, 1)), m);
            if (i >= 12 && i < 20 && !cmd[11]) rd = {rd[6:0], m};
            else if (m !== 1'b0) miso_bad++;
        end
        repeat (4) @(negedge clk);
        cs = 1'b1;
        mosi = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic check_cfg(input string name, input logic [2:0] a, input logic [7:0] exp);
        cfg_addr = a;
        #1;
        check(name, cfg_data, exp);
    endtask

    initial begin
        vec_t vt[6];
        logic [7:0] rd;
        int bad, w0, r0;
        logic m;

        vt[0] = '{12'hA5C, 12, 8, 1'b1, 3'd2, 8'h5C, 1'b0, 8'h00};
        vt[1] = '{12'h200, 20, 8, 1'b0, 3'd0, 8'h00, 1'b1, 8'h5C};
        vt[2] = '{12'h911, 12, 4, 1'b1, 3'd1, 8'h11, 1'b0, 8'h00};
        vt[3] = '{12'h100, 20, 8, 1'b0, 3'd0, 8'h00, 1'b1, 8'h11};
        vt[4] = '{12'h8AA, 16, 8, 1'b1, 3'd0, 8'hAA, 1'b0, 8'h00};
        vt[5] = '{12'h000, 20, 8, 1'b0, 3'd0, 8'h00, 1'b1, 8'hAA};
        for (int i = 0; i < 8; i++) mdl[i] = 8'h00;

        repeat (5) @(negedge clk);
        check("rst_miso", miso, 1'b0);
        check("rst_wr_vld", wr_vld, 1'b0);
        check("rst_wr_addr", wr_addr, 3'd0);
        check("rst_wr_data", wr_data, 8'h00);
        check("rst_rd_done", rd_done, 1'b0);
        check_cfg("rst_cfg", 3'd2, 8'h00);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        for (int v = 0; v < 6; v++) begin
            w0 = wr_cnt;
            r0 = rd_cnt;
            frame(vt[v].cmd, vt[v].nrise, vt[v].gap, rd, bad);
            check("vec_wr_count", 32'(wr_cnt - w0), {31'd0, vt[v].exp_wr});
            check("vec_rd_count", 32'(rd_cnt - r0), {31'd0, vt[v].exp_rd});
            check("vec_miso_idle", bad, 0);
            if (vt[v].exp_wr) begin
                check("vec_wr_addr", mon_addr, vt[v].exp_addr);
                check("vec_wr_data", mon_data, vt[v].exp_wdata);
                check_cfg("vec_cfg", vt[v].exp_addr, vt[v].exp_wdata);
            end else begin
                check("vec_rd_data", rd, vt[v].exp_rdata);
            end
        end

        // Aborted write, then the same frame in full
        w0 = wr_cnt; r0 = rd_cnt;
        frame(12'hF3A, 7, 8, rd, bad);
        check("abort_wr_count", wr_cnt - w0, 0);
        check("abort_rd_count", rd_cnt - r0, 0);
        check_cfg("abort_reg7", 3'd7, 8'h00);
        w0 = wr_cnt;
        frame(12'hF3A, 12, 8, rd, bad);
        check("after_abort_wr_count", wr_cnt - w0, 1);
        check("after_abort_wr_addr", mon_addr, 3'd7);
        check_cfg("after_abort_reg7", 3'd7, 8'h3A);

        // Reset mid-frame with cs held low
        w0 = wr_cnt;
        @(negedge clk);
        cs = 1'b0;
        repeat (5) @(negedge clk);
        for (int i = 0; i < 5; i++) pulse(i == 0 ? 1'b1 : (i == 1 ? 1'b0 : 1'b1), m);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("midrst_miso", miso, 1'b0);
        check("midrst_wr_vld", wr_vld, 1'b0);
        check("midrst_wr_addr", wr_addr, 3'd0);
        check("midrst_wr_data", wr_data, 8'h00);
        check("midrst_rd_done", rd_done, 1'b0);
        check_cfg("midrst_reg7_cleared", 3'd7, 8'h00);
        rst_n = 1'b1;
        for (int i = 0; i < 7; i++) pulse(1'b1, m);
        repeat (4) @(negedge clk);
        cs = 1'b1;
        repeat (8) @(negedge clk);
        check("midrst_wr_count", wr_cnt - w0, 0);
        check_cfg("midrst_reg3", 3'd3, 8'h00);

        // Random frames against the array model
        for (int n = 0; n < 40; n++) begin
            int kind, nr;
            logic [11:0] cmd;
            logic [2:0] ra;
            kind = $urandom_range(0, 4);
            cmd = 12'($urandom);
            if (kind <= 1) cmd[11] = 1'b1;
            else if (kind <= 3) cmd[11] = 1'b0;
            if (kind == 4) nr = cmd[11] ? $urandom_range(1, 11) : $urandom_range(1, 19);
            else if (cmd[11]) nr = 12 + $urandom_range(0, 3);
            else nr = 20 + $urandom_range(0, 2);
            w0 = wr_cnt; r0 = rd_cnt;
            frame(cmd, nr, 4 + $urandom_range(0, 6), rd, bad);
            check("rnd_miso_idle", bad, 0);
            if (kind == 4) begin
                check("rnd_abort_wr", wr_cnt - w0, 0);
                check("rnd_abort_rd", rd_cnt - r0, 0);
            end else if (cmd[11]) begin
                mdl[cmd[10:8]] = cmd[7:0];
                check("rnd_wr_count", wr_cnt - w0, 1);
                check("rnd_rd_none", rd_cnt - r0, 0);
                check("rnd_wr_addr", mon_addr, cmd[10:8]);
                check("rnd_wr_data", mon_data, cmd[7:0]);
            end else begin
                check("rnd_rd_count", rd_cnt - r0, 1);
                check("rnd_wr_none", wr_cnt - w0, 0);
                check("rnd_rd_data", rd, mdl[cmd[10:8]]);
            end
            ra = 3'($urandom_range(0, 7));
            check_cfg("rnd_cfg", ra, mdl[ra]);
        end

        for (int a = 0; a < 8; a++) check_cfg("final_cfg", 3'(a), mdl[a]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
